// File: rtl/dkong_rom_loader.sv
// Registers the HPS ioctl ROM download into the dkong_top download port, tags each byte with
// a one-hot ROM region, checks the byte count and owns the core reset.
module dkong_rom_loader #(
  parameter logic [18:0] R1_BASE   = 19'h04000,
  parameter logic [18:0] R2_BASE   = 19'h05000,
  parameter logic [18:0] R3_BASE   = 19'h06000,
  parameter logic [18:0] TOTAL_LEN = 19'h07300,
  parameter int unsigned HOLD_CYC  = 16
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        ioctl_download_i,
  input  logic        ioctl_wr_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_dout_i,
  input  logic        ext_reset_i,
  output logic [18:0] dn_addr_o,
  output logic [7:0]  dn_data_o,
  output logic        dn_wr_o,
  output logic [3:0]  dn_region_o,
  output logic        core_resetn_o,
  output logic        dl_busy_o,
  output logic        dl_error_o
);

  localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {StWait, StLoad, StHold, StRun, StErr} state_e;

  state_e            state_q, state_d;
  logic              dl_q;
  logic [18:0]       byte_cnt_q, byte_cnt_d;
  logic              ovf_q, ovf_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [18:0]       dn_addr_q, dn_addr_d;
  logic [7:0]        dn_data_q, dn_data_d;
  logic              dn_wr_q, dn_wr_d;
  logic [3:0]        dn_region_q, dn_region_d;
  logic              dl_error_q, dl_error_d;
  logic              core_resetn_q, dl_busy_q;

  logic        dl_rise, dl_fall, in_range, wr_ok, wr_bad;
  logic [18:0] wr_addr;
  logic [3:0]  wr_region;

  assign dl_rise  = ioctl_download_i & ~dl_q;
  assign dl_fall  = ~ioctl_download_i & dl_q;
  assign in_range = ioctl_addr_i < {6'd0, TOTAL_LEN};
  assign wr_ok    = (state_q == StLoad) && ioctl_wr_i && in_range;
  assign wr_bad   = (state_q == StLoad) && ioctl_wr_i && !in_range;
  assign wr_addr  = ioctl_addr_i[18:0];

  always_comb begin
    wr_region = 4'b1000;
    if (wr_addr < R1_BASE)      wr_region = 4'b0001;
    else if (wr_addr < R2_BASE) wr_region = 4'b0010;
    else if (wr_addr < R3_BASE) wr_region = 4'b0100;
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    ovf_d       = ovf_q;
    hold_cnt_d  = hold_cnt_q;
    dl_error_d  = dl_error_q;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    dn_wr_d     = 1'b0;
    dn_region_d = 4'b0000;

    if (wr_ok) begin
      dn_wr_d     = 1'b1;
      dn_addr_d   = wr_addr;
      dn_data_d   = ioctl_dout_i;
      dn_region_d = wr_region;
      if (byte_cnt_q != TOTAL_LEN) byte_cnt_d = byte_cnt_q + 19'd1;
    end
    if (wr_bad) ovf_d = 1'b1;

    if (dl_rise) begin
      state_d    = StLoad;
      byte_cnt_d = '0;
      ovf_d      = 1'b0;
      dl_error_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          // Decision includes a write landing on the falling-edge cycle itself.
          if (dl_fall) begin
            if (byte_cnt_d == TOTAL_LEN && !ovf_d) begin
              state_d    = StHold;
              hold_cnt_d = '0;
            end else begin
              state_d    = StErr;
              dl_error_d = 1'b1;
            end
          end
        end
        StHold: begin
          if (ext_reset_i)                  hold_cnt_d = '0;
          else if (hold_cnt_q == HoldLast)  state_d = StRun;
          else                              hold_cnt_d = hold_cnt_q + 1'b1;
        end
        StRun: begin
          if (ext_reset_i) begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StWait;
      dl_q          <= 1'b0;
      byte_cnt_q    <= '0;
      ovf_q         <= 1'b0;
      hold_cnt_q    <= '0;
      dn_addr_q     <= '0;
      dn_data_q     <= '0;
      dn_wr_q       <= 1'b0;
      dn_region_q   <= '0;
      dl_error_q    <= 1'b0;
      core_resetn_q <= 1'b0;
      dl_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dl_q          <= ioctl_download_i;
      byte_cnt_q    <= byte_cnt_d;
      ovf_q         <= ovf_d;
      hold_cnt_q    <= hold_cnt_d;
      dn_addr_q     <= dn_addr_d;
      dn_data_q     <= dn_data_d;
      dn_wr_q       <= dn_wr_d;
      dn_region_q   <= dn_region_d;
      dl_error_q    <= dl_error_d;
      core_resetn_q <= (state_d == StRun);
      dl_busy_q     <= (state_d == StLoad);
    end
  end

  assign dn_addr_o     = dn_addr_q;
  assign dn_data_o     = dn_data_q;
  assign dn_wr_o       = dn_wr_q;
  assign dn_region_o   = dn_region_q;
  assign core_resetn_o = core_resetn_q;
  assign dl_busy_o     = dl_busy_q;
  assign dl_error_o    = dl_error_q;

endmodule

// File: tb/tb_dkong_rom_loader.sv
// Bench for dkong_rom_loader: boundary vector table plus full/short/overflow loads, hold timing,
// external reset and asynchronous reset sequences, with a scoreboard on the dn_* port.
module tb_dkong_rom_loader;

  localparam int unsigned HoldCyc  = 16;
  localparam int unsigned TotalLen = 32'h7300;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr, ext_reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [18:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr, core_resetn, dl_busy, dl_error;
  logic [3:0]  dn_region;

  always #5 clk = ~clk;

  dkong_rom_loader dut (
    .clk_sys_i        (clk),
    .reset_i          (reset),
    .ioctl_download_i (ioctl_download),
    .ioctl_wr_i       (ioctl_wr),
    .ioctl_addr_i     (ioctl_addr),
    .ioctl_dout_i     (ioctl_dout),
    .ext_reset_i      (ext_reset),
    .dn_addr_o        (dn_addr),
    .dn_data_o        (dn_data),
    .dn_wr_o          (dn_wr),
    .dn_region_o      (dn_region),
    .core_resetn_o    (core_resetn),
    .dl_busy_o        (dl_busy),
    .dl_error_o       (dl_error)
  );

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
    logic [3:0]  region;
  } exp_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    bit          fwd;
    logic [3:0]  region;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] region_of(input logic [18:0] a);
    if (a < 19'h04000) return 4'b0001;
    if (a < 19'h05000) return 4'b0010;
    if (a < 19'h06000) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic [7:0] dgen(input int unsigned i);
    logic [31:0] v;
    v = i;
    return v[7:0] ^ v[15:8] ^ 8'hA5;
  endfunction

  // Drive one cycle of ioctl stimulus at the falling edge; queue the expected forward.
  task automatic cyc(input logic dl, input logic wr, input logic [24:0] addr,
                     input logic [7:0] data, input bit fwd, input logic [3:0] region);
    exp_t e;
    @(negedge clk);
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = addr;
    ioctl_dout     = data;
    if (fwd) begin
      e.addr   = addr[18:0];
      e.data   = data;
      e.region = region;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 25'h0, 8'h0, 1'b0, 4'h0);
  endtask

  // Rising-edge cycle carries an ignored write; last in-range write lands on the falling edge.
  task automatic load_seq(input int unsigned n, input int bad_at);
    cyc(1'b1, 1'b1, 25'h10, 8'hEE, 1'b0, 4'h0);
    for (int i = 0; i < int'(n); i++) begin
      if (i == bad_at) begin
        cyc(1'b1, 1'b1, 25'h0007300, 8'h77, 1'b0, 4'h0);
        cyc(1'b1, 1'b1, 25'h1000000, 8'h78, 1'b0, 4'h0);
      end
      cyc(i != int'(n) - 1, 1'b1, 25'(i), dgen(i), 1'b1, region_of(19'(i)));
      if (i == 0) begin
        check("dl_busy in load", dl_busy, 1);
        check("dl_error cleared by new download", dl_error, 0);
      end
    end
  endtask

  task automatic chk_rst_vals();
    check("rst dn_addr", dn_addr, 0);
    check("rst dn_data", dn_data, 0);
    check("rst dn_wr", dn_wr, 0);
    check("rst dn_region", dn_region, 0);
    check("rst core_resetn", core_resetn, 0);
    check("rst dl_busy", dl_busy, 0);
    check("rst dl_error", dl_error, 0);
  endtask

  task automatic chk_err();
    idle();
    check("err dl_error", dl_error, 1);
    check("err dl_busy", dl_busy, 0);
    check("err core_resetn", core_resetn, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("dn_wr strobe", dn_wr, 1);
      check("dn_addr", dn_addr, e.addr);
      check("dn_data", dn_data, e.data);
      check("dn_region", dn_region, e.region);
    end else begin
      check("no dn_wr expected", dn_wr, 0);
      check("dn_region idle", dn_region, 0);
    end
  end

  initial begin
    vecs[0]  = '{25'h0000000, 8'h01, 1'b1, 4'b0001};
    vecs[1]  = '{25'h0003FFF, 8'h3F, 1'b1, 4'b0001};
    vecs[2]  = '{25'h0004000, 8'h40, 1'b1, 4'b0010};
    vecs[3]  = '{25'h0004FFF, 8'h4F, 1'b1, 4'b0010};
    vecs[4]  = '{25'h0005000, 8'h50, 1'b1, 4'b0100};
    vecs[5]  = '{25'h0005FFF, 8'h5F, 1'b1, 4'b0100};
    vecs[6]  = '{25'h0006000, 8'h60, 1'b1, 4'b1000};
    vecs[7]  = '{25'h00072FF, 8'h72, 1'b1, 4'b1000};
    vecs[8]  = '{25'h0007300, 8'h73, 1'b0, 4'b0000};
    vecs[9]  = '{25'h1000000, 8'h99, 1'b0, 4'b0000};
    vecs[10] = '{25'h1FFFFFF, 8'hFF, 1'b0, 4'b0000};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ext_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst_vals();
    reset = 1'b0;
    idle();

    // Boundary table as one short download, ending in ERR.
    cyc(1'b1, 1'b0, 25'h0, 8'h0, 1'b0, 4'h0);
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].fwd, vecs[i].region);
      check("dl_busy table", dl_busy, 1);
    end
    idle();
    chk_err();
    // Writes and ext_reset in ERR are ignored.
    cyc(1'b0, 1'b1, 25'h123, 8'h5A, 1'b0, 4'h0);
    ext_reset = 1'b1;
    repeat (3) begin
      idle();
      check("ERR ignores ext_reset", core_resetn, 0);
      check("ERR keeps dl_error", dl_error, 1);
    end
    ext_reset = 1'b0;

    // Full count but overflow writes mid-load -> ERR.
    load_seq(TotalLen, 100);
    chk_err();

    // One byte short -> ERR.
    load_seq(TotalLen - 1, -1);
    chk_err();

    // Full load -> HOLD for HoldCyc cycles -> RUN.
    load_seq(TotalLen, -1);
    idle();
    check("hold dl_busy", dl_busy, 0);
    check("hold dl_error", dl_error, 0);
    check("hold core_resetn", core_resetn, 0);
    for (int j = 1; j < int'(HoldCyc); j++) begin
      idle();
      check("hold core_resetn", core_resetn, 0);
    end
    idle();
    check("run core_resetn", core_resetn, 1);

    // ext_reset pulse of 5 cycles in RUN.
    ext_reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle();
      check("ext_reset core_resetn", core_resetn, 0);
    end
    ext_reset = 1'b0;
    for (int j = 0; j < int'(HoldCyc) - 1; j++) begin
      idle();
      check("ext hold core_resetn", core_resetn, 0);
    end
    idle();
    check("ext rerun core_resetn", core_resetn, 1);

    // Async reset in RUN.
    reset = 1'b1;
    #1;
    chk_rst_vals();
    idle();
    chk_rst_vals();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 25'(k), 8'hC0, 1'b0, 4'h0);
    idle();
    check("wait core_resetn", core_resetn, 0);
    check("wait dl_busy", dl_busy, 0);

    // Async reset mid-LOAD with a write registered and another presented.
    cyc(1'b1, 1'b0, 25'h0, 8'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 25'h4100, 8'hAB, 1'b1, 4'b0010);
    cyc(1'b1, 1'b1, 25'h4101, 8'hCD, 1'b1, 4'b0010);
    cyc(1'b1, 1'b1, 25'h4102, 8'hEF, 1'b0, 4'h0);
    reset = 1'b1;
    #1;
    chk_rst_vals();
    idle();
    chk_rst_vals();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 25'h200 + 25'(k), 8'h33, 1'b0, 4'h0);
    idle();
    check("post-reset dl_busy", dl_busy, 0);

    // A new download forwards again.
    load_seq(4, -1);
    chk_err();
    idle();
    idle();
    check("scoreboard drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
